stage_4_mem: RTL and testbench

Memory-access pipeline stage of the 5-stage CPU. It sits between the execute stage (stage 3) and the write-back stage (stage 5). It registers the EX→MEM bus and aligns and extends load data returned by the synchronous data SRAM. It also produces the 70-bit MEM→WB bus and a bypass bus for the decode stage. It implements the standard valid/allow pipeline handshake and holds returned load data while write-back back-pressures.

---
 rtl/stage_4_mem.sv | 100 ++++++++++
 tb/tb_stage_4_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stage_4_mem.sv
// Memory-access pipeline stage: registers the EX->MEM bus, aligns and extends
// SRAM load data, and drives the MEM->WB bus plus a decode-stage bypass.
module stage_4_mem (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_3,
  output logic        allow_4,
  input  logic [73:0] stage_3_to_4,
  input  logic [31:0] data_sram_rdata,
  output logic        valid_4,
  input  logic        allow_5,
  output logic [69:0] stage_4_to_5,
  output logic [37:0] fwd_4
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 5;

  typedef struct packed {
    logic [2:0]        load_op;
    logic              res_from_mem;
    logic              rf_we;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc;
  } ex_mem_t;

  logic              valid_r;
  ex_mem_t           bus_r;
  logic [DATA_W-1:0] rdata_hold;
  logic              held;

  logic              readygo_4;
  logic              hold_load;
  logic [DATA_W-1:0] eff;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;

  assign readygo_4 = 1'b1;
  assign allow_4   = !valid_r || (readygo_4 && allow_5);
  assign valid_4   = valid_r && readygo_4;

  // SRAM data is only valid for one cycle; capture it the first time WB stalls a load.
  assign hold_load = valid_r && bus_r.res_from_mem && !held && !allow_5;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r    <= 1'b0;
      bus_r      <= '0;
      rdata_hold <= '0;
      held       <= 1'b0;
    end else begin
      if (allow_4) begin
        valid_r <= valid_3;
        if (valid_3) begin
          bus_r <= stage_3_to_4;
          held  <= 1'b0;
        end
      end
      if (hold_load) begin
        rdata_hold <= data_sram_rdata;
        held       <= 1'b1;
      end
    end
  end

  assign eff = held ? rdata_hold : data_sram_rdata;

  // Byte/half lane select from the low address bits.
  always_comb begin
    byte_sel = eff[7:0];
    case (bus_r.alu_result[1:0])
      2'd0:    byte_sel = eff[7:0];
      2'd1:    byte_sel = eff[15:8];
      2'd2:    byte_sel = eff[23:16];
      default: byte_sel = eff[31:24];
    endcase
    half_sel = bus_r.alu_result[1] ? eff[31:16] : eff[15:0];
  end

  always_comb begin
    load_data = eff;
    case (bus_r.load_op)
      3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd3:    load_data = {24'd0, byte_sel};
      3'd4:    load_data = {16'd0, half_sel};
      default: load_data = eff;
    endcase
  end

  assign final_result = bus_r.res_from_mem ? load_data : bus_r.alu_result;

  assign stage_4_to_5 = {bus_r.rf_we && valid_r, bus_r.dest, final_result, bus_r.pc};
  assign fwd_4        = {valid_r && bus_r.rf_we && (bus_r.dest != DEST_W'(0)),
                         bus_r.dest, final_result};

endmodule

// File: tb/tb_stage_4_mem.sv
// Bench for stage_4_mem: directed spec cases plus random traffic checked
// against an occupancy/age reference model of the stage.
module tb_stage_4_mem;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_3;
  logic        allow_4;
  logic [73:0] stage_3_to_4;
  logic [31:0] data_sram_rdata;
  logic        valid_4;
  logic        allow_5;
  logic [69:0] stage_4_to_5;
  logic [37:0] fwd_4;

  int checks = 0;
  int errors = 0;

  // Reference model: what instruction sits in the stage, how many cycles it has
  // been stalled, and the SRAM data it saw on its first cycle.
  logic        mv;
  logic [2:0]  m_op;
  logic        m_rfm;
  logic        m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_alu;
  logic [31:0] m_pc;
  int          age;
  logic [31:0] first_rd;

  always #5 clk = ~clk;

  stage_4_mem dut (
    .clk             (clk),
    .resetn          (resetn),
    .valid_3         (valid_3),
    .allow_4         (allow_4),
    .stage_3_to_4    (stage_3_to_4),
    .data_sram_rdata (data_sram_rdata),
    .valid_4         (valid_4),
    .allow_5         (allow_5),
    .stage_4_to_5    (stage_4_to_5),
    .fwd_4           (fwd_4)
  );

  task automatic chk(input string tag, input logic [73:0] got, input logic [73:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [73:0] mk(input logic [2:0] op, input logic rfm, input logic we,
                                     input logic [4:0] dest, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {op, rfm, we, dest, alu, pc};
  endfunction

  // Load result from plain shift/mask arithmetic on the word.
  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    int unsigned sh;
    sh = 8 * int'(a);
    b = (w >> sh) & 32'hFF;
    h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
    if (op == 3'd1) return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
    if (op == 3'd2) return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
    if (op == 3'd3) return b;
    if (op == 3'd4) return h;
    return w;
  endfunction

  // One cycle: drive at negedge, check model, take the edge, advance model.
  task automatic step(input logic v3, input logic [73:0] bus, input logic [31:0] rd,
                      input logic a5);
    logic [31:0] eff, fin;
    valid_3 = v3;
    stage_3_to_4 = bus;
    data_sram_rdata = rd;
    allow_5 = a5;
    #1;
    if (mv && age == 0) first_rd = rd;
    eff = (age == 0) ? rd : first_rd;
    fin = m_rfm ? load_val(m_op, m_alu[1:0], eff) : m_alu;
    chk("valid_4", 74'(valid_4), 74'(mv));
    chk("allow_4", 74'(allow_4), 74'(!mv || a5));
    if (mv) begin
      chk("stage_4_to_5", 74'(stage_4_to_5), 74'({m_we, m_dest, fin, m_pc}));
      chk("fwd_4", 74'(fwd_4), 74'({m_we && (m_dest != 5'd0), m_dest, fin}));
    end else begin
      chk("idle_rf_we", 74'(stage_4_to_5[69]), 74'(0));
      chk("idle_fwd_we", 74'(fwd_4[37]), 74'(0));
    end
    @(posedge clk);
    if (!mv || a5) begin
      mv = v3;
      if (v3) begin
        {m_op, m_rfm, m_we, m_dest, m_alu, m_pc} = bus;
        age = 0;
      end
    end else begin
      age++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_valid_4", 74'(valid_4), 74'(0));
    chk("rst_s45", 74'(stage_4_to_5), 74'(0));
    chk("rst_fwd", 74'(fwd_4), 74'(0));
    chk("rst_allow_4", 74'(allow_4), 74'(1));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mv = 1'b0;
    age = 0;
  endtask

  initial begin
    logic [31:0] rd;
    resetn = 1'b1;
    valid_3 = 1'b0;
    stage_3_to_4 = '0;
    data_sram_rdata = '0;
    allow_5 = 1'b1;
    mv = 1'b0;
    age = 0;
    first_rd = '0;
    @(negedge clk);
    do_reset();

    // ALU pass-through
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0010), 32'h0, 1'b1);
    chk("alu_s45", 74'(stage_4_to_5), 74'({1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0010}));
    chk("alu_fwd", 74'(fwd_4), 74'({1'b1, 5'd5, 32'h1234_5678}));

    // Load extension
    rd = 32'h80FF_7F01;
    step(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd6, 32'h0000_1003, 32'h1C00_0014), rd, 1'b1);
    chk("ld_b", 74'(stage_4_to_5[63:32]), 74'(32'hFFFF_FF80));
    step(1'b1, mk(3'd3, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0018), rd, 1'b1);
    chk("ld_bu", 74'(stage_4_to_5[63:32]), 74'(32'h0000_0080));
    step(1'b1, mk(3'd2, 1'b1, 1'b1, 5'd8, 32'h0000_1002, 32'h1C00_001C), rd, 1'b1);
    chk("ld_h", 74'(stage_4_to_5[63:32]), 74'(32'hFFFF_80FF));
    step(1'b1, mk(3'd4, 1'b1, 1'b1, 5'd9, 32'h0000_1000, 32'h1C00_0020), rd, 1'b1);
    chk("ld_hu", 74'(stage_4_to_5[63:32]), 74'(32'h0000_7F01));
    step(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd10, 32'h0000_1001, 32'h1C00_0024), rd, 1'b1);
    chk("ld_w", 74'(stage_4_to_5[63:32]), 74'(32'h80FF_7F01));

    // Stall hold: SRAM data changes while WB back-pressures
    step(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd11, 32'h0000_2000, 32'h1C00_0028), 32'h1357_9BDF, 1'b1);
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd12, 32'hAAAA_0000, 32'h1C00_002C), 32'h1357_9BDF, 1'b0);
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd12, 32'hAAAA_0000, 32'h1C00_002C), 32'hDEAD_BEEF, 1'b0);
    chk("stall_data", 74'(stage_4_to_5[63:32]), 74'(32'h1357_9BDF));
    chk("stall_allow_4", 74'(allow_4), 74'(0));
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd12, 32'hAAAA_0000, 32'h1C00_002C), 32'hDEAD_BEEF, 1'b0);
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd12, 32'hAAAA_0000, 32'h1C00_002C), 32'hDEAD_BEEF, 1'b1);
    chk("stall_release_pc", 74'(stage_4_to_5[31:0]), 74'(32'h1C00_002C));

    // Back-to-back then bubble
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd1, 32'h0000_0001, 32'h1C00_0100), 32'h0, 1'b1);
    chk("b2b_0", 74'(stage_4_to_5[31:0]), 74'(32'h1C00_0100));
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd2, 32'h0000_0002, 32'h1C00_0104), 32'h0, 1'b1);
    chk("b2b_1", 74'(stage_4_to_5[31:0]), 74'(32'h1C00_0104));
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd3, 32'h0000_0003, 32'h1C00_0108), 32'h0, 1'b1);
    chk("b2b_2", 74'(stage_4_to_5[31:0]), 74'(32'h1C00_0108));
    step(1'b0, '0, 32'h0, 1'b1);
    chk("bubble_valid_4", 74'(valid_4), 74'(0));
    chk("bubble_fwd_we", 74'(fwd_4[37]), 74'(0));

    // dest = 0 suppresses bypass only
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd0, 32'h0000_00AA, 32'h1C00_0200), 32'h0, 1'b1);
    chk("dest0_fwd_we", 74'(fwd_4[37]), 74'(0));
    chk("dest0_rf_we", 74'(stage_4_to_5[69]), 74'(1));

    // Reset in the middle of a stalled load
    step(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd4, 32'h0000_0001, 32'h1C00_0300), 32'h0000_8000, 1'b1);
    step(1'b0, '0, 32'h0000_8000, 1'b0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic [73:0] b;
      b = mk(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom),
             $urandom, $urandom);
      step(($urandom_range(0, 3) != 0), b, $urandom, ($urandom_range(0, 9) < 6));
    end
    step(1'b0, '0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
